// File: rtl/fence_sequencer.sv
// Fence sequencer: turns one committed fence-class op into an ordered
// D-cache writeback / I-cache / TLB flush sequence, a drain window and a done pulse.
module fence_sequencer #(
    parameter logic        DCACHE_WB      = 1'b1,
    parameter logic        RVH            = 1'b1,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter int unsigned DCACHE_TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       v_i,
    input  logic       req_valid_i,
    input  logic [2:0] req_op_i,
    output logic       req_ready_o,
    output logic       flush_dcache_o,
    input  logic       flush_dcache_ack_i,
    output logic       flush_icache_o,
    output logic       flush_tlb_o,
    output logic       flush_tlb_vvma_o,
    output logic       flush_tlb_gvma_o,
    output logic       halt_o,
    output logic       done_o,
    output logic       timeout_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DCACHE,
        S_ICACHE,
        S_TLB,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_FENCE       = 3'd0;
    localparam logic [2:0] OP_FENCE_I     = 3'd1;
    localparam logic [2:0] OP_SFENCE_VMA  = 3'd2;
    localparam logic [2:0] OP_HFENCE_VVMA = 3'd3;
    localparam logic [2:0] OP_HFENCE_GVMA = 3'd4;

    localparam logic        TO_EN      = (DCACHE_TIMEOUT != 0);
    localparam logic [15:0] TO_LAST    = 16'(DCACHE_TIMEOUT - 1);
    localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES);
    // With no drain window every "go to drain" lands straight on DONE.
    localparam state_t      POST_FLUSH = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic        v_q;
    logic [15:0] to_cnt;
    logic [7:0]  drain_cnt;

    logic        accept;
    logic [2:0]  op_sel;
    logic        v_sel;
    logic        to_hit;
    logic        tlb_plain, tlb_vvma, tlb_gvma;

    assign accept = req_valid_i && (state == S_IDLE);
    assign op_sel = accept ? req_op_i : op_q;
    assign v_sel  = accept ? (v_i & RVH) : v_q;

    always_comb begin
        state_nxt = state;
        to_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    case (req_op_i)
                        OP_FENCE:       state_nxt = DCACHE_WB ? S_DCACHE : POST_FLUSH;
                        OP_FENCE_I:     state_nxt = DCACHE_WB ? S_DCACHE : S_ICACHE;
                        OP_SFENCE_VMA:  state_nxt = S_TLB;
                        OP_HFENCE_VVMA,
                        OP_HFENCE_GVMA: state_nxt = RVH ? S_TLB : POST_FLUSH;
                        default:        state_nxt = POST_FLUSH;
                    endcase
                end
            end
            S_DCACHE: begin
                // Ack takes priority over a timeout landing on the same cycle.
                if (flush_dcache_ack_i) begin
                    state_nxt = (op_q == OP_FENCE_I) ? S_ICACHE : POST_FLUSH;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    to_hit    = 1'b1;
                    state_nxt = (op_q == OP_FENCE_I) ? S_ICACHE : POST_FLUSH;
                end
            end
            S_ICACHE: state_nxt = POST_FLUSH;
            S_TLB:    state_nxt = POST_FLUSH;
            S_DRAIN:  if (drain_cnt <= 8'd1) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Which TLB flavour fires is decided from the op/v being latched, so the
    // registered pulse lines up with the TLB state.
    always_comb begin
        tlb_plain = 1'b0;
        tlb_vvma  = 1'b0;
        tlb_gvma  = 1'b0;
        case (op_sel)
            OP_SFENCE_VMA: begin
                if (RVH && v_sel) tlb_vvma  = 1'b1;
                else              tlb_plain = 1'b1;
            end
            OP_HFENCE_VVMA: tlb_vvma = 1'b1;
            OP_HFENCE_GVMA: tlb_gvma = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= S_IDLE;
            op_q             <= 3'd0;
            v_q              <= 1'b0;
            to_cnt           <= 16'd0;
            drain_cnt        <= 8'd0;
            req_ready_o      <= 1'b1;
            flush_dcache_o   <= 1'b0;
            flush_icache_o   <= 1'b0;
            flush_tlb_o      <= 1'b0;
            flush_tlb_vvma_o <= 1'b0;
            flush_tlb_gvma_o <= 1'b0;
            halt_o           <= 1'b0;
            done_o           <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept) begin
                op_q      <= req_op_i;
                v_q       <= v_i & RVH;
                to_cnt    <= 16'd0;
                drain_cnt <= DRAIN_INIT;
            end else begin
                if (state == S_DCACHE) to_cnt    <= to_cnt + 16'd1;
                if (state == S_DRAIN)  drain_cnt <= drain_cnt - 8'd1;
            end

            if (accept)      timeout_o <= 1'b0;
            else if (to_hit) timeout_o <= 1'b1;

            // Moore outputs, registered from the next state.
            req_ready_o      <= (state_nxt == S_IDLE);
            halt_o           <= (state_nxt != S_IDLE);
            flush_dcache_o   <= (state_nxt == S_DCACHE);
            flush_icache_o   <= (state_nxt == S_ICACHE);
            flush_tlb_o      <= (state_nxt == S_TLB) && tlb_plain;
            flush_tlb_vvma_o <= (state_nxt == S_TLB) && tlb_vvma;
            flush_tlb_gvma_o <= (state_nxt == S_TLB) && tlb_gvma;
            done_o           <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_fence_sequencer.sv
// Bench for fence_sequencer: three parameter variants, directed cases then a
// randomized run, each checked cycle-by-cycle against a trace built from the op rules.
module tb_fence_sequencer;

    localparam int ND = 3;

    typedef struct packed {
        logic ready;
        logic fd;
        logic fi;
        logic ft;
        logic fv;
        logic fg;
        logic halt;
        logic done;
        logic tmo;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic [ND-1:0]      v, req_valid, ack;
    logic [ND-1:0][2:0] op;
    logic [ND-1:0]      ready, fd, fi, ft, fv, fg, halt, done, tmo;

    always #5 clk = ~clk;

    // u0: full config, short timeout. u1: no WB D-cache, no RVH. u2: no drain, no timeout.
    fence_sequencer #(.DCACHE_WB(1'b1), .RVH(1'b1), .DRAIN_CYCLES(2), .DCACHE_TIMEOUT(8)) u0 (
        .clk_i(clk), .rst_i(rst), .v_i(v[0]), .req_valid_i(req_valid[0]), .req_op_i(op[0]),
        .req_ready_o(ready[0]), .flush_dcache_o(fd[0]), .flush_dcache_ack_i(ack[0]),
        .flush_icache_o(fi[0]), .flush_tlb_o(ft[0]), .flush_tlb_vvma_o(fv[0]),
        .flush_tlb_gvma_o(fg[0]), .halt_o(halt[0]), .done_o(done[0]), .timeout_o(tmo[0]));

    fence_sequencer #(.DCACHE_WB(1'b0), .RVH(1'b0), .DRAIN_CYCLES(2), .DCACHE_TIMEOUT(0)) u1 (
        .clk_i(clk), .rst_i(rst), .v_i(v[1]), .req_valid_i(req_valid[1]), .req_op_i(op[1]),
        .req_ready_o(ready[1]), .flush_dcache_o(fd[1]), .flush_dcache_ack_i(ack[1]),
        .flush_icache_o(fi[1]), .flush_tlb_o(ft[1]), .flush_tlb_vvma_o(fv[1]),
        .flush_tlb_gvma_o(fg[1]), .halt_o(halt[1]), .done_o(done[1]), .timeout_o(tmo[1]));

    fence_sequencer #(.DCACHE_WB(1'b1), .RVH(1'b1), .DRAIN_CYCLES(0), .DCACHE_TIMEOUT(0)) u2 (
        .clk_i(clk), .rst_i(rst), .v_i(v[2]), .req_valid_i(req_valid[2]), .req_op_i(op[2]),
        .req_ready_o(ready[2]), .flush_dcache_o(fd[2]), .flush_dcache_ack_i(ack[2]),
        .flush_icache_o(fi[2]), .flush_tlb_o(ft[2]), .flush_tlb_vvma_o(fv[2]),
        .flush_tlb_gvma_o(fg[2]), .halt_o(halt[2]), .done_o(done[2]), .timeout_o(tmo[2]));

    function automatic logic p_wb(int d);    return d != 1;           endfunction
    function automatic logic p_rvh(int d);   return d != 1;           endfunction
    function automatic int   p_drain(int d); return (d == 2) ? 0 : 2; endfunction
    function automatic int   p_to(int d);    return (d == 0) ? 8 : 0; endfunction

    int   checks   = 0;
    int   failures = 0;
    logic tmo_prev [ND];
    obs_t exp_q [$];
    int   dc_len;

    function automatic obs_t sample(int d);
        obs_t r;
        r.ready = ready[d]; r.fd = fd[d]; r.fi = fi[d]; r.ft = ft[d]; r.fv = fv[d];
        r.fg = fg[d]; r.halt = halt[d]; r.done = done[d]; r.tmo = tmo[d];
        return r;
    endfunction

    function automatic obs_t idle_rec(logic t);
        obs_t r;
        r = '0;
        r.ready = 1'b1;
        r.tmo   = t;
        return r;
    endfunction

    task automatic check(int d, obs_t exp_v, string tag, int cyc);
        obs_t o;
        o = sample(d);
        checks++;
        assert (o === exp_v) else begin
            failures++;
            $error("FAIL %s dut%0d cyc%0d observed=%b expected=%b (rdy,fd,fi,ft,fv,fg,halt,done,tmo)",
                   tag, d, cyc, o, exp_v);
        end
    endtask

    // Expected per-cycle trace; entry 0 is the IDLE accept cycle.
    task automatic build(int d, logic [2:0] opc, logic vv, int ack_at);
        obs_t r;
        logic vl, to_fired;
        int   n;
        exp_q.delete();
        vl       = vv & p_rvh(d);
        to_fired = 1'b0;
        dc_len   = 0;
        exp_q.push_back(idle_rec(tmo_prev[d]));
        if ((opc == 3'd0 || opc == 3'd1) && p_wb(d)) begin
            if (ack_at > 0 && (p_to(d) == 0 || ack_at <= p_to(d))) n = ack_at;
            else begin n = p_to(d); to_fired = 1'b1; end
            dc_len = n;
            for (int i = 0; i < n; i++) begin
                r = '0; r.fd = 1'b1; r.halt = 1'b1; exp_q.push_back(r);
            end
        end
        r = '0; r.halt = 1'b1; r.tmo = to_fired;
        if (opc == 3'd1) begin r.fi = 1'b1; exp_q.push_back(r); r.fi = 1'b0; end
        if (opc == 3'd2) begin
            if (vl) r.fv = 1'b1; else r.ft = 1'b1;
            exp_q.push_back(r); r.fv = 1'b0; r.ft = 1'b0;
        end
        if (opc == 3'd3 && p_rvh(d)) begin r.fv = 1'b1; exp_q.push_back(r); r.fv = 1'b0; end
        if (opc == 3'd4 && p_rvh(d)) begin r.fg = 1'b1; exp_q.push_back(r); r.fg = 1'b0; end
        for (int i = 0; i < p_drain(d); i++) exp_q.push_back(r);
        r.done = 1'b1;
        exp_q.push_back(r);
        tmo_prev[d] = to_fired;
    endtask

    task automatic run(int d, logic [2:0] opc, logic vv, int ack_at, int gap, bit hold, string tag);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check(d, idle_rec(tmo_prev[d]), {tag, "_gap"}, -1);
            req_valid[d] = 1'b0;
            v[d]   = 1'($urandom_range(0, 1));
            ack[d] = 1'($urandom_range(0, 1));
        end
        build(d, opc, vv, ack_at);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            check(d, exp_q[c], tag, c);
            req_valid[d] = (c == 0) || hold;
            op[d]  = opc;
            v[d]   = (c == 0) ? vv : 1'($urandom_range(0, 1));
            ack[d] = (c >= 1 && c <= dc_len) ? (c == ack_at) : 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        int   d, pd, ack_at, gap;
        logic [2:0] opc, pop;
        logic vv;
        bit   hold, phold;
        obs_t r;

        rst = 1'b1;
        req_valid = '0; v = '0; ack = '0; op = '0;
        for (int i = 0; i < ND; i++) tmo_prev[i] = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < ND; i++) check(i, idle_rec(1'b0), "reset_state", 0);
        rst = 1'b0;

        run(0, 3'd2, 1'b0, 0, 1, 0, "sfence_v0");
        run(0, 3'd1, 1'b0, 3, 1, 0, "fence_i_ack3");
        run(0, 3'd0, 1'b0, 0, 1, 0, "fence_timeout");
        run(0, 3'd2, 1'b1, 0, 2, 0, "sfence_v1_clr_tmo");
        run(0, 3'd4, 1'b0, 0, 0, 0, "hfence_gvma");
        run(0, 3'd0, 1'b0, 8, 1, 0, "ack_eq_timeout");
        run(1, 3'd3, 1'b1, 0, 1, 0, "hvvma_norvh");
        run(1, 3'd2, 1'b1, 0, 0, 0, "sfence_norvh");
        run(1, 3'd0, 1'b0, 0, 0, 0, "fence_nowb");
        run(1, 3'd1, 1'b0, 0, 0, 0, "fence_i_nowb");
        run(2, 3'd6, 1'b0, 0, 1, 0, "illegal_nodrain");
        run(2, 3'd2, 1'b0, 0, 0, 1, "b2b_first");
        run(2, 3'd2, 1'b0, 0, 0, 0, "b2b_second");
        run(2, 3'd0, 1'b0, 1, 1, 0, "ack_first_cycle");

        // Reset landing on the second D-cache cycle of u0.
        @(negedge clk);
        check(0, idle_rec(tmo_prev[0]), "rst_seq_accept", 0);
        req_valid[0] = 1'b1; op[0] = 3'd0; ack[0] = 1'b0;
        @(negedge clk);
        r = '0; r.fd = 1'b1; r.halt = 1'b1;
        check(0, r, "rst_seq_dc1", 1);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check(0, r, "rst_seq_dc2", 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < ND; i++) tmo_prev[i] = 1'b0;
        check(0, idle_rec(1'b0), "rst_seq_after", 3);
        @(negedge clk);
        check(0, idle_rec(1'b0), "rst_seq_no_done", 4);
        run(0, 3'd0, 1'b0, 2, 0, 0, "fence_after_rst");

        phold = 1'b0; pd = 0; pop = 3'd0;
        for (int it = 0; it < 60; it++) begin
            d      = phold ? pd : int'($urandom_range(0, ND - 1));
            opc    = phold ? pop : 3'($urandom_range(0, 7));
            vv     = 1'($urandom_range(0, 1));
            ack_at = (p_to(d) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 11));
            gap    = phold ? 0 : int'($urandom_range(0, 2));
            hold   = (it != 59) && ($urandom_range(0, 3) == 0);
            run(d, opc, vv, ack_at, gap, hold, "random");
            phold = hold; pd = d; pop = opc;
        end

        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < ND; i++) check(i, idle_rec(tmo_prev[i]), "final_idle", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fence_sequencer.md
Name: fence_sequencer

Overview:
- Serialises fence-class operations (FENCE, FENCE.I, SFENCE.VMA, HFENCE.VVMA, HFENCE.GVMA) issued by commit into an ordered flush sequence: D-cache writeback flush with ack, I-cache flush, TLB flush, then a drain window.
- Sits between the commit stage and the cache/MMU subsystem. Halts commit while a sequence is in flight.
- Signals completion with a single-cycle done pulse.

Parameters:
- DCACHE_WB, 1'b1: write-back D-cache present. When 0, the D-cache flush step is skipped.
- RVH, 1'b1: hypervisor extension. When 0, HFENCE ops perform no flush and v_i is ignored.
- DRAIN_CYCLES, 2: idle cycles after the flush steps, before done. 0 skips the drain. Valid range 0..255.
- DCACHE_TIMEOUT, 1024: maximum cycles to wait for the D-cache ack. 0 disables the timeout. Valid range 0..65535.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- v_i  in  1  virtualization mode, sampled at accept
- req_valid_i  in  1  fence request valid
- req_op_i  in  3  operation: 0 FENCE, 1 FENCE_I, 2 SFENCE_VMA, 3 HFENCE_VVMA, 4 HFENCE_GVMA, 5..7 illegal
- req_ready_o  out  1  request accepted this cycle when high together with req_valid_i
- flush_dcache_o  out  1  D-cache flush request, held until ack
- flush_dcache_ack_i  in  1  D-cache flush complete
- flush_icache_o  out  1  I-cache flush, 1-cycle pulse
- flush_tlb_o  out  1  full TLB flush, 1-cycle pulse
- flush_tlb_vvma_o  out  1  VS-stage TLB flush, 1-cycle pulse
- flush_tlb_gvma_o  out  1  G-stage TLB flush, 1-cycle pulse
- halt_o  out  1  halt commit
- done_o  out  1  sequence complete, 1-cycle pulse
- timeout_o  out  1  sticky: last D-cache flush timed out

Behaviour:
- Reset: state is IDLE. All outputs are 0 except req_ready_o=1. Counters, latched op, latched v and timeout_o are cleared.
- Reset mid-sequence: the next cycle is IDLE with all flush outputs 0. No done_o is produced.
- States: IDLE, DCACHE, ICACHE, TLB, DRAIN, DONE.
- All outputs are Moore outputs decoded from state, except req_ready_o = (state==IDLE).
- IDLE:
  - On req_valid_i & req_ready_o in cycle T: latch op and v_i, clear timeout_o, load counters.
  - Next state in T+1, by op:
    - FENCE: DCACHE if DCACHE_WB, else DRAIN.
    - FENCE_I: DCACHE if DCACHE_WB, else ICACHE.
    - SFENCE_VMA: TLB.
    - HFENCE_VVMA / HFENCE_GVMA: TLB if RVH, else DRAIN.
    - Illegal op: DRAIN.
- DCACHE:
  - flush_dcache_o=1. The timeout counter increments each cycle.
  - On flush_dcache_ack_i=1: exit.
  - If DCACHE_TIMEOUT!=0 and the counter reaches DCACHE_TIMEOUT-1 without ack: set timeout_o and exit.
  - Ack and timeout in the same cycle: ack wins, timeout_o stays 0.
  - Exit target: ICACHE for FENCE_I, DRAIN for FENCE.
- ICACHE: flush_icache_o=1 for exactly one cycle, then DRAIN.
- TLB: one cycle, then DRAIN. Exactly one output is asserted:
  - SFENCE_VMA with RVH & latched v=1: flush_tlb_vvma_o.
  - SFENCE_VMA otherwise: flush_tlb_o.
  - HFENCE_VVMA: flush_tlb_vvma_o.
  - HFENCE_GVMA: flush_tlb_gvma_o.
- DRAIN: stays DRAIN_CYCLES cycles (8-bit down-counter), then DONE. With DRAIN_CYCLES=0 the step is bypassed: every transition into DRAIN goes directly to DONE.
- DONE: done_o=1 for one cycle, then IDLE. req_ready_o=0 in DONE; the next accept is possible in the IDLE cycle after DONE.
- halt_o = (state!=IDLE).
- flush_dcache_ack_i is ignored outside DCACHE, including a stale ack held high at entry to any other state. An ack already high on the first DCACHE cycle is honoured, so DCACHE lasts a minimum of 1 cycle.
- req_valid_i while busy is not accepted. The requester holds req_valid_i and req_op_i stable until accepted.
- v_i changes after accept have no effect on the sequence.

Test Plan:
- SFENCE_VMA, v_i=0, DRAIN_CYCLES=2, accept at T -> flush_tlb_o at T+1, DRAIN T+2..T+3, done_o at T+4, halt_o high T+1..T+4, req_ready_o high again at T+5.
- FENCE_I, DCACHE_WB=1, ack at 3rd DCACHE cycle -> flush_dcache_o T+1..T+3, flush_icache_o T+4, done_o at T+7 (DRAIN_CYCLES=2), timeout_o=0.
- FENCE, DCACHE_TIMEOUT=8, no ack -> flush_dcache_o for 8 cycles T+1..T+8, timeout_o=1 from T+9, done_o at T+11; next accept clears timeout_o.
- RVH=1: SFENCE_VMA with v_i=1 -> only flush_tlb_vvma_o; HFENCE_GVMA -> only flush_tlb_gvma_o. RVH=0: HFENCE_VVMA -> no TLB pulse, done_o at T+3.
- rst_i asserted during the 2nd DCACHE cycle -> all outputs 0 and req_ready_o=1 the next cycle; no done_o; a subsequent FENCE sequence completes normally.
- DRAIN_CYCLES=0, illegal op 6 -> done_o at T+1. Back-to-back requests held valid -> accepts at T and T+3 (SFENCE), no overlap of flush pulses.
